// File: rtl/i4001_cycle_ctrl.sv
// i4001 machine-cycle timing controller.
// A programmable prescaler sets the phase length. The control FSM sequences the
// eight machine states (A1 A2 A3 M1 M2 X1 X2 X3), two phases per state, and
// drives PHI1/PHI2, SYNC, the state index and a cycle-done strobe. It runs either
// continuously or one instruction cycle per STEP rising edge.
module i4001_cycle_ctrl #(
   parameter int DIV_W       = 15,
   parameter int DIV_DEFAULT = 20000
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_div_load,
   input  logic [DIV_W-1:0] i_div_val,
   input  logic             i_run,
   input  logic             i_step,
   output logic             o_phi1,
   output logic             o_phi2,
   output logic             o_sync,
   output logic [2:0]       o_state,
   output logic             o_busy,
   output logic             o_cyc_done
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RUN_ST  = 2'd1,
      STEP_ST = 2'd2
   } ctrl_e;

   localparam logic [2:0] X3 = 3'd7;

   ctrl_e            r_ctrl;
   ctrl_e            w_ctrl_nxt;

   logic [DIV_W-1:0] r_q;
   logic [DIV_W-1:0] r_div;
   logic             r_ph;
   logic [2:0]       r_state;
   logic             r_phi1;
   logic             r_phi2;
   logic             r_sync;
   logic             r_busy;
   logic             r_cyc_done;
   logic             r_step_q;

   logic [DIV_W-1:0] w_q_nxt;
   logic [DIV_W-1:0] w_div_nxt;
   logic             w_ph_nxt;
   logic [2:0]       w_state_nxt;
   logic             w_phi1_nxt;
   logic             w_phi2_nxt;
   logic             w_sync_nxt;
   logic             w_busy_nxt;
   logic             w_cyc_done_nxt;

   logic             w_tick;
   logic             w_step_edge;
   logic             w_end;

   // The prescaler only counts while a cycle is in progress; it is held at 0 in IDLE.
   assign w_tick      = (r_ctrl != IDLE) && (r_q == r_div);
   // A step request is the rising edge of the STEP level, so a held switch yields one cycle.
   assign w_step_edge = i_step & ~r_step_q;
   // The last tick of the instruction cycle: X3, phase 2.
   assign w_end       = w_tick && r_ph && (r_state == X3);

   // Control state register.
   // NOTE: sequential state is updated with non-blocking assignments so every
   // register samples the pre-edge values, independent of block ordering.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_ctrl <= IDLE;
      end else begin
         r_ctrl <= w_ctrl_nxt;
      end
   end

   // Next control state: RUN beats a simultaneous STEP edge; a cycle never ends early.
   // NOTE: every signal written here gets a default first, otherwise an unassigned
   // path would infer a latch.
   always_comb begin
      w_ctrl_nxt = r_ctrl;
      unique case (r_ctrl)
         IDLE: begin
            if (i_run) begin
               w_ctrl_nxt = RUN_ST;
            end else if (w_step_edge) begin
               w_ctrl_nxt = STEP_ST;
            end
         end
         RUN_ST: begin
            if (w_end && !i_run) begin
               w_ctrl_nxt = IDLE;
            end
         end
         STEP_ST: begin
            if (w_end) begin
               w_ctrl_nxt = IDLE;
            end
         end
         default: w_ctrl_nxt = IDLE;
      endcase
   end

   // Next values for prescaler, divide register, phase sequencer and registered outputs.
   always_comb begin
      w_q_nxt        = r_q;
      w_div_nxt      = r_div;
      w_ph_nxt       = r_ph;
      w_state_nxt    = r_state;
      w_phi1_nxt     = r_phi1;
      w_phi2_nxt     = r_phi2;
      w_busy_nxt     = r_busy;
      w_cyc_done_nxt = 1'b0;

      if (r_ctrl == IDLE) begin
         // Divide value may only change between cycles so a phase length never shifts mid-cycle.
         if (i_div_load) begin
            w_div_nxt = i_div_val;
         end
         w_q_nxt     = '0;
         w_ph_nxt    = 1'b0;
         w_state_nxt = 3'd0;
         w_phi2_nxt  = 1'b0;
         // Entering a cycle starts directly in A1 phase 1.
         w_phi1_nxt  = (w_ctrl_nxt != IDLE);
         w_busy_nxt  = (w_ctrl_nxt != IDLE);
      end else begin
         w_cyc_done_nxt = w_end;
         if (w_tick) begin
            w_q_nxt = '0;
            if (!r_ph) begin
               w_ph_nxt   = 1'b1;
               w_phi1_nxt = 1'b0;
               w_phi2_nxt = 1'b1;
            end else if (w_ctrl_nxt == IDLE) begin
               w_ph_nxt    = 1'b0;
               w_state_nxt = 3'd0;
               w_phi1_nxt  = 1'b0;
               w_phi2_nxt  = 1'b0;
               w_busy_nxt  = 1'b0;
            end else begin
               // Wraps X3 -> A1 with no gap cycle when free-running.
               w_ph_nxt    = 1'b0;
               w_state_nxt = r_state + 3'd1;
               w_phi1_nxt  = 1'b1;
               w_phi2_nxt  = 1'b0;
            end
         end else begin
            w_q_nxt = r_q + DIV_W'(1);
         end
      end

      // SYNC derives from the next STATE so it lines up with the registered state index.
      w_sync_nxt = w_busy_nxt && (w_state_nxt == X3);
   end

   // Datapath and output registers, plus the STEP edge-detector history.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_q        <= '0;
         r_div      <= DIV_W'(DIV_DEFAULT);
         r_ph       <= 1'b0;
         r_state    <= 3'd0;
         r_phi1     <= 1'b0;
         r_phi2     <= 1'b0;
         r_sync     <= 1'b0;
         r_busy     <= 1'b0;
         r_cyc_done <= 1'b0;
         r_step_q   <= 1'b0;
      end else begin
         r_q        <= w_q_nxt;
         r_div      <= w_div_nxt;
         r_ph       <= w_ph_nxt;
         r_state    <= w_state_nxt;
         r_phi1     <= w_phi1_nxt;
         r_phi2     <= w_phi2_nxt;
         r_sync     <= w_sync_nxt;
         r_busy     <= w_busy_nxt;
         r_cyc_done <= w_cyc_done_nxt;
         r_step_q   <= i_step;
      end
   end

   assign o_phi1     = r_phi1;
   assign o_phi2     = r_phi2;
   assign o_sync     = r_sync;
   assign o_state    = r_state;
   assign o_busy     = r_busy;
   assign o_cyc_done = r_cyc_done;

endmodule

// File: tb/tb_i4001_cycle_ctrl.sv
// Self-checking bench for i4001_cycle_ctrl.
// The reference model tracks the position inside the instruction cycle as a plain
// CLK count and derives state/phase arithmetically; every posedge it pushes the
// expected output vector, and a negedge monitor pops and compares.
module tb_i4001_cycle_ctrl;

   localparam int DIV_W       = 15;
   localparam int DIV_DEFAULT = 20000;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             div_load = 1'b0;
   logic [DIV_W-1:0] div_val = '0;
   logic             run = 1'b0;
   logic             step = 1'b0;

   logic             phi1;
   logic             phi2;
   logic             sync;
   logic [2:0]       state;
   logic             busy;
   logic             cyc_done;

   i4001_cycle_ctrl #(
      .DIV_W      (DIV_W),
      .DIV_DEFAULT(DIV_DEFAULT)
   ) dut (
      .i_clk     (clk),
      .i_rst     (rst),
      .i_div_load(div_load),
      .i_div_val (div_val),
      .i_run     (run),
      .i_step    (step),
      .o_phi1    (phi1),
      .o_phi2    (phi2),
      .o_sync    (sync),
      .o_state   (state),
      .o_busy    (busy),
      .o_cyc_done(cyc_done)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc_n    = 0;
   int n_done_dut = 0;

   logic [7:0] exp_q[$];

   // Reference model: mode 0=idle, 1=free-run, 2=single-step.
   int m_mode = 0;
   int m_pos  = 0;
   int m_div  = DIV_DEFAULT;
   bit m_stepq = 1'b0;
   bit m_done  = 1'b0;

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc_n, act, exp);
      end
   endtask

   function automatic int m_idx();
      return (m_mode != 0) ? (m_pos / (m_div + 1)) : 0;
   endfunction

   function automatic logic [7:0] model_out();
      bit         b;
      int         idx;
      logic [2:0] st;
      bit         ph;
      b   = (m_mode != 0);
      idx = m_idx();
      st  = 3'(idx / 2);
      ph  = (idx % 2) == 1;
      return {b && !ph, b && ph, b && (st == 3'd7), st, b, m_done};
   endfunction

   task automatic model_update();
      bit edge_seen;
      if (rst) begin
         m_mode  = 0;
         m_pos   = 0;
         m_div   = DIV_DEFAULT;
         m_stepq = 1'b0;
         m_done  = 1'b0;
         return;
      end
      edge_seen = step && !m_stepq;
      m_stepq   = step;
      m_done    = 1'b0;
      if (m_mode == 0) begin
         if (div_load) m_div = int'(div_val);
         if (run) begin
            m_mode = 1;
            m_pos  = 0;
         end else if (edge_seen) begin
            m_mode = 2;
            m_pos  = 0;
         end
      end else begin
         m_pos++;
         if (m_pos == 16 * (m_div + 1)) begin
            m_done = 1'b1;
            m_pos  = 0;
            if (!(m_mode == 1 && run)) m_mode = 0;
         end
      end
   endtask

   // One CLK: model follows the edge, expectation is queued, inputs may change 1 time unit later.
   task automatic cyc(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         cyc_n++;
         model_update();
         exp_q.push_back(model_out());
         #1;
      end
   endtask

   // Monitor: compares the DUT outputs against the queued expectation away from the active edge.
   initial begin
      logic [7:0] e;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("outputs", {phi1, phi2, sync, state, busy, cyc_done}, e);
            check("phi_overlap", {7'b0, phi1 & phi2}, 8'h00);
            if (cyc_done) n_done_dut++;
         end
      end
   end

   initial begin
      bit found;
      bit prev_rst;

      // 1. Reset defaults, then free-run with the default divide.
      rst = 1'b1;
      cyc(2);
      check("reset_busy", {7'b0, busy}, 8'h00);
      check("reset_state", {5'b0, state}, 8'h00);
      rst = 1'b0;
      run = 1'b1;
      cyc(20005);

      // 2. Fast free-run with divide 1.
      rst = 1'b1;
      run = 1'b0;
      cyc(1);
      rst = 1'b0;
      div_load = 1'b1;
      div_val  = DIV_W'(1);
      cyc(1);
      div_load = 1'b0;
      run = 1'b1;
      n_done_dut = 0;
      cyc(100);
      run = 1'b0;
      cyc(40);
      check("free_run_done_count", 8'(n_done_dut), 8'd4);

      // 3. Single step with STEP held, then a second step.
      div_load = 1'b1;
      div_val  = '0;
      cyc(1);
      div_load = 1'b0;
      cyc(1);
      n_done_dut = 0;
      step = 1'b1;
      cyc(50);
      check("step_one_cycle", 8'(n_done_dut), 8'd1);
      check("step_idle_after", {7'b0, busy}, 8'h00);
      step = 1'b0;
      cyc(2);
      step = 1'b1;
      cyc(20);
      check("step_second_cycle", 8'(n_done_dut), 8'd2);
      step = 1'b0;
      cyc(1);

      // 4. RUN dropped in M1: the cycle still completes.
      run = 1'b1;
      found = 1'b0;
      for (int i = 0; i < 100 && !found; i++) begin
         cyc(1);
         if (m_mode != 0 && m_idx() / 2 == 3) found = 1'b1;
      end
      check("wait_m1", {7'b0, found}, 8'h01);
      run = 1'b0;
      cyc(20);
      check("mid_stop_idle", {7'b0, busy}, 8'h00);

      // 5. Load ignored while busy, honoured once idle.
      div_load = 1'b1;
      div_val  = DIV_W'(1);
      cyc(1);
      div_load = 1'b0;
      run = 1'b1;
      cyc(5);
      div_load = 1'b1;
      div_val  = DIV_W'(5);
      cyc(1);
      div_load = 1'b0;
      cyc(20);
      run = 1'b0;
      cyc(40);
      div_load = 1'b1;
      cyc(1);
      div_load = 1'b0;
      run = 1'b1;
      cyc(30);
      run = 1'b0;
      cyc(110);

      // 6. Reset in X1 phase 2, then confirm the default divide is back.
      div_load = 1'b1;
      div_val  = DIV_W'(1);
      cyc(1);
      div_load = 1'b0;
      run = 1'b1;
      found = 1'b0;
      for (int i = 0; i < 100 && !found; i++) begin
         cyc(1);
         if (m_mode != 0 && m_idx() == 11) found = 1'b1;
      end
      check("wait_x1_ph1", {7'b0, found}, 8'h01);
      rst = 1'b1;
      cyc(1);
      check("rst_mid_busy", {7'b0, busy}, 8'h00);
      rst = 1'b0;
      cyc(40);
      run = 1'b0;

      // Randomized traffic; a reset is always followed by a short divide load.
      prev_rst = 1'b0;
      for (int i = 0; i < 4000; i++) begin
         rst = ($urandom_range(0, 299) == 0);
         div_load = prev_rst || ($urandom_range(0, 9) == 0);
         div_val  = DIV_W'($urandom_range(0, 3));
         if ($urandom_range(0, 19) == 0) run = ~run;
         if ($urandom_range(0, 7) == 0) step = ~step;
         prev_rst = rst;
         cyc(1);
      end

      rst = 1'b1;
      run = 1'b0;
      step = 1'b0;
      div_load = 1'b0;
      cyc(2);
      repeat (3) @(negedge clk);
      check("queue_drained", 8'(exp_q.size()), 8'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/i4001_cycle_ctrl.md
Name: i4001_cycle_ctrl

Overview:
- Programmable timing controller for the i4001 design. Owns the clock-divide prescaler and sequences the 8-state machine cycle A1 A2 A3 M1 M2 X1 X2 X3, two phases per state.
- Generates non-overlapping PHI1/PHI2 phase levels, SYNC, a state index and a cycle-done strobe.
- Supports free-run and single-instruction-cycle step modes, so the ROM logic can be exercised at human speed or stepped from a debug switch.

Parameters:
- DIV_W, 15, width of prescaler counter and divide register.
- DIV_DEFAULT, 20000, divide value loaded at reset. Phase length = DIV_DEFAULT+1 CLK cycles.

Ports:
- CLK  in  1  system clock; all logic on posedge.
- RST  in  1  synchronous, active-high reset.
- DIV_LOAD  in  1  load DIV_VAL into divide register; honoured only in IDLE.
- DIV_VAL  in  DIV_W  new divide value.
- RUN  in  1  level; free-run request.
- STEP  in  1  level; rising edge requests one instruction cycle.
- PHI1  out  1  phase-1 level.
- PHI2  out  1  phase-2 level.
- SYNC  out  1  high for the entire X3 state (both phases).
- STATE  out  3  A1=0, A2=1, A3=2, M1=3, M2=4, X1=5, X2=6, X3=7.
- BUSY  out  1  high when not IDLE.
- CYC_DONE  out  1  one-CLK pulse at the end of X3 phase 2.

Behaviour:
- Reset (synchronous, RST=1 at posedge): ctrl=IDLE; prescaler Q=0; div_reg=DIV_DEFAULT; ph=0; STATE=0.
  - All outputs 0: PHI1, PHI2, SYNC, BUSY, CYC_DONE.
  - STEP edge detector register cleared to 0.
  - RST overrides every other input, including mid-cycle.
- Prescaler:
  - While BUSY: Q increments each CLK. tick=1 when Q==div_reg, and Q<=0 on that cycle.
  - In IDLE: Q is held at 0.
  - div_reg=0 gives a tick on every CLK.
- Divide load:
  - DIV_LOAD=1 in IDLE: div_reg<=DIV_VAL on the next edge.
  - DIV_LOAD while BUSY is ignored and not queued.
- Control FSM, states IDLE, RUN_ST, STEP_ST. All outputs are registered.
  - IDLE to RUN_ST: RUN=1.
  - IDLE to STEP_ST: RUN=0 and STEP rising edge, where step_edge = STEP & ~STEP_q.
  - RUN and a STEP edge in the same cycle: RUN wins.
  - On entry (first cycle with BUSY=1): STATE=A1, ph=0, PHI1=1, PHI2=0, Q=0.
- Sequencing on each tick:
  - ph=0: ph<=1, PHI1<=0, PHI2<=1.
  - ph=1: ph<=0, STATE<=STATE+1 (wraps 7 to 0), PHI2<=0, PHI1<=1.
  - PHI1 and PHI2 are never both 1.
  - Each phase lasts div_reg+1 CLKs. One instruction cycle = 16*(div_reg+1) CLKs.
- SYNC = (STATE==X3) while BUSY, driven as a registered output aligned with STATE.
- End of cycle, on the tick with STATE=X3 and ph=1:
  - CYC_DONE=1 for exactly that following CLK.
  - RUN_ST with RUN=1: wrap to A1/ph0, PHI1=1; no gap cycle.
  - RUN_ST with RUN=0: go to IDLE. PHI1, PHI2, SYNC and BUSY=0; STATE=0.
  - STEP_ST: always go to IDLE.
- RUN deasserted mid-cycle: the current cycle completes; no truncation.
- STEP edges while BUSY are ignored; they are not queued.
- RUN asserted during STEP_ST: the step cycle completes to IDLE, then RUN_ST is entered on the next CLK if RUN is still 1.
- STEP held high produces exactly one cycle; a new step needs STEP to go low, then high again.

Test Plan:
1. Reset defaults: RST=1 for 2 CLK, then RUN=1 -> PHI1=1 on the first BUSY cycle; PHI1 remains high 20001 CLKs (DIV_DEFAULT), then PHI2=1.
2. Fast free-run: RST, DIV_LOAD=1 with DIV_VAL=1, then RUN=1 for 100 CLK.
   - Each phase lasts 2 CLK.
   - CYC_DONE pulses every 32 CLK.
   - SYNC is high 4 CLK per cycle, coincident with STATE=7.
   - STATE steps 0..7 and wraps.
3. Single step: DIV_VAL=0, STEP held high 50 CLK with RUN=0.
   - Exactly one 16-CLK cycle and one CYC_DONE, then BUSY=0.
   - STEP low, then high again: a second cycle runs.
4. Mid-cycle stop: DIV_VAL=0, RUN=1, then RUN=0 at STATE=M1 -> sequencing continues through X3; CYC_DONE=1; BUSY=0 on the next CLK.
5. Ignored load: while BUSY with div=1, DIV_LOAD with DIV_VAL=5 -> phase length stays 2 CLK.
   - After return to IDLE, the same load gives 6-CLK phases.
6. Reset mid-operation: RST=1 at STATE=X1, ph=1 -> next CLK all outputs 0, BUSY=0, div_reg=20000.
   - Randomized check: PHI1 & PHI2 is never 1.
